// File: rtl/fifo_sc_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_sc_wr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FDONE = 2'd3
  } arb_state_e;

  // Width needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_sc_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_grant, with wrap.
module fifo_sc_wr_arb_rr_pick
  import fifo_sc_wr_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [GW-1:0]    last_grant_i,
  output logic             any_o,
  output logic [GW-1:0]    winner_o
);

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    int idx;
    idx      = 0;
    any_o    = |req_i;
    winner_o = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last_grant_i) + k) % N_REQ;
      if (req_i[GW'(idx)]) begin
        winner_o = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_sc_wr_arb.sv
// Round-robin burst arbiter and flush sequencer sharing one FIFO write port.
module fifo_sc_wr_arb
  import fifo_sc_wr_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int DW        = 8,
  parameter  int MAX_BURST = 4,
  parameter  int TIMEOUT   = 8,
  localparam int GW        = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_last,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                flush_req,
  output logic                flush_done,
  input  logic                fifo_full,
  output logic                fifo_we,
  output logic [DW-1:0]       fifo_din,
  output logic                fifo_clr,
  output logic [GW-1:0]       grant_id,
  output logic                busy
);

  localparam int BW = cnt_width(MAX_BURST);
  localparam int IW = cnt_width(TIMEOUT);

  arb_state_e      state_q;
  logic [GW-1:0]   grant_id_q;
  logic [GW-1:0]   last_grant_q;
  logic [BW-1:0]   beat_cnt_q;
  logic [IW-1:0]   idle_cnt_q;
  logic            busy_q;
  logic            fifo_clr_q;
  logic            flush_done_q;

  logic            pick_any;
  logic [GW-1:0]   pick_idx_d;
  logic            in_burst;
  logic            gnt_valid;
  logic            gnt_last;
  logic            beat_acc;
  logic [DW-1:0]   data_a [N_REQ];

  fifo_sc_wr_arb_rr_pick #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_rr_pick (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .any_o        (pick_any),
    .winner_o     (pick_idx_d)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign data_a[gi]    = req_data[gi*DW +: DW];
      assign req_ready[gi] = in_burst && (grant_id_q == GW'(gi)) && !fifo_full;
    end
  endgenerate

  assign in_burst  = (state_q == ST_BURST);
  assign gnt_valid = req_valid[grant_id_q];
  assign gnt_last  = req_last[grant_id_q];
  // A full FIFO stalls the beat without counting as idle: counters hold.
  assign beat_acc  = in_burst && gnt_valid && !fifo_full;

  assign fifo_we    = beat_acc;
  assign fifo_din   = in_burst ? data_a[grant_id_q] : '0;
  assign fifo_clr   = fifo_clr_q;
  assign flush_done = flush_done_q;
  assign grant_id   = grant_id_q;
  assign busy       = busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      busy_q       <= 1'b0;
      fifo_clr_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      fifo_clr_q   <= 1'b0;
      flush_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (flush_req) begin
            state_q    <= ST_FLUSH;
            fifo_clr_q <= 1'b1;
            busy_q     <= 1'b1;
          end else if (pick_any) begin
            state_q      <= ST_BURST;
            grant_id_q   <= pick_idx_d;
            last_grant_q <= pick_idx_d;
            beat_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            busy_q       <= 1'b1;
          end
        end
        ST_BURST: begin
          if (beat_acc) begin
            idle_cnt_q <= '0;
            if (gnt_last || (beat_cnt_q == BW'(MAX_BURST - 1))) begin
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
              beat_cnt_q <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end else if (!gnt_valid) begin
            if (idle_cnt_q == IW'(TIMEOUT - 1)) begin
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
              idle_cnt_q <= '0;
              beat_cnt_q <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          state_q      <= ST_FDONE;
          flush_done_q <= 1'b1;
          busy_q       <= 1'b0;
        end
        ST_FDONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
